// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
//   XLEN          : address / instruction width
//   NOP_INSTR     : instruction shown to decode when the queue is empty
//   fetch_entry_t : one queued fetch {pc, instr, misaligned}
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misaligned;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory and decode.
//   imem_req/imem_addr/imem_rdata : synchronous 1-cycle-latency memory read
//   fetch_valid/fetch_ready       : decode handshake
//   fetch_pc/fetch_instr/fetch_misaligned : head entry payload
// master = fetch queue side, slave = memory/decode side.
interface fetch_queue_if;

  logic                      imem_req;
  logic [fetch_pkg::XLEN-1:0] imem_addr;
  logic [fetch_pkg::XLEN-1:0] imem_rdata;
  logic                      fetch_valid;
  logic                      fetch_ready;
  logic [fetch_pkg::XLEN-1:0] fetch_pc;
  logic [fetch_pkg::XLEN-1:0] fetch_instr;
  logic                      fetch_misaligned;

  modport master (
    output imem_req, imem_addr, fetch_valid, fetch_pc, fetch_instr, fetch_misaligned,
    input  imem_rdata, fetch_ready
  );

  modport slave (
    input  imem_req, imem_addr, fetch_valid, fetch_pc, fetch_instr, fetch_misaligned,
    output imem_rdata, fetch_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t.
//   clk       : clock
//   clear     : synchronous clear (reset or redirect), wins over push/pop
//   push      : write push_data at the tail
//   push_data : entry to write
//   pop       : drop the head entry
//   count     : number of valid entries (0..DEPTH)
//   head      : head entry; a NOP at PC 0 when empty
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; count gates what is visible.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    head = '{pc: '0, instr: NOP_INSTR, misaligned: 1'b0};
    if (count != '0) head = mem[rd_ptr];
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (clear)
    !(push && count == CW'(DEPTH)));

  a_no_underflow: assert property (@(posedge clk) disable iff (clear)
    !(pop && count == '0));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage between the PC register and decode.
// Issues one memory read per cycle while there is room, tags the returned
// word with its PC and queues it for decode.
//   clk       : clock
//   rst       : synchronous reset, active-high
//   pc_in     : current PC
//   flush     : redirect taken this cycle (PC jump)
//   stall_out : 1 = PC must hold
//   occupancy : queued entry count
//   bus       : memory read port and decode handshake (master side)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XLEN-1:0]        pc_in,
  input  logic                   flush,
  output logic                   stall_out,
  output logic [$clog2(DEPTH):0] occupancy,
  fetch_queue_if.master          bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = CW + 1;

  logic [CW-1:0]  count;
  logic [PW-1:0]  committed;
  logic           issue;
  logic           inflight;
  logic [XLEN-1:0] inflight_pc;
  logic           inflight_mis;
  logic           push;
  logic           pop;
  fetch_entry_t   head;
  fetch_entry_t   push_data;

  // Credit counts queued plus outstanding entries only; a same-cycle pop
  // earns no credit so fetch_ready never reaches stall_out.
  assign committed = PW'(count) + PW'(inflight);
  assign issue     = !rst && !flush && (committed < PW'(DEPTH));

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_in;
  assign stall_out     = !issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      inflight_mis <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc  <= pc_in;
        inflight_mis <= is_misaligned(pc_in);
      end
    end
  end

  // A response arriving in a flush cycle belongs to the old path.
  assign push      = inflight && !flush;
  assign pop       = bus.fetch_valid && bus.fetch_ready && !flush;
  assign push_data = '{pc: inflight_pc, instr: bus.imem_rdata, misaligned: inflight_mis};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .clear     (rst || flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign occupancy            = count;
  assign bus.fetch_valid      = (count != '0);
  assign bus.fetch_pc         = head.pc;
  assign bus.fetch_instr      = head.instr;
  assign bus.fetch_misaligned = head.misaligned;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction-fetch stage directly downstream of the program counter.
- Each cycle it accepts the current PC (pc_in) and issues a read to a synchronous instruction memory with fixed 1-cycle latency.
- It captures each returned word, tagged with its PC, into a DEPTH-entry FIFO.
- It presents queued instructions to decode through a valid/ready handshake.
- It drives stall back to the PC when it cannot take another fetch, and discards all queued and in-flight work on a redirect (flush, the same signal that drives the PC's j_signal).

Parameters:
DEPTH, 4, FIFO entries. Power of two, ≥2. ≥3 is required for 1 instr/cycle sustained throughput.
XLEN, 32, address/instruction width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
pc_in  in  XLEN  current PC from the PC register (stable all cycle)
flush  in  1  redirect/jump taken this cycle (same net as PC j_signal)
stall_out  out  1  to PC stall input; 1 = hold PC
imem_req  out  1  instruction memory read enable
imem_addr  out  XLEN  read address (= pc_in)
imem_rdata  in  XLEN  read data, valid the cycle after imem_req
fetch_valid  out  1  head entry valid to decode
fetch_ready  in  1  decode accepts head this cycle
fetch_pc  out  XLEN  PC of head entry
fetch_instr  out  XLEN  instruction of head entry
fetch_misaligned  out  1  head entry PC had bits[1:0] != 0
occupancy  out  $clog2(DEPTH)+1  current FIFO count

Behaviour:
- Reset is synchronous and active-high on rst, single clock clk.
- Reset values: count=0, inflight=0, FIFO pointers 0.
  - fetch_valid=0, fetch_pc=0, fetch_instr=NOP (32'h00000013), fetch_misaligned=0, occupancy=0.
  - stall_out=1 while rst high.
- Issue (combinational): issue = !rst && !flush && (count + inflight) < DEPTH.
  - imem_req = issue; imem_addr = pc_in; stall_out = !issue.
  - No credit is taken for a same-cycle pop. This keeps fetch_ready off the stall path.
- In-flight tracking: on issue, register inflight=1, inflight_pc=pc_in and inflight_mis=(pc_in[1:0]!=0). Otherwise inflight=0.
  - At most one request is outstanding.
- Response: in the cycle after an issue, if !flush, push {inflight_pc, imem_rdata, inflight_mis}.
  - If flush is high in that cycle, drop the response.
- Pop: when fetch_valid && fetch_ready && !flush, advance rd pointer.
- Simultaneous push and pop: count unchanged, pointers both advance.
- Push while full: cannot occur, because the issue credit rule prevents it.
  - Implementation must assert (simulation-only) on overflow and on pop while empty.
- Flush (highest priority over push/pop):
  - next cycle count=0, pointers reset to 0, inflight=0, fetch_valid=0.
  - No issue in the flush cycle; the PC loads the jump target, and the first fetch of the target issues the cycle after.
- Outputs are driven from the FIFO head: fetch_valid = (count != 0).
  - When empty: fetch_pc=0, fetch_instr=NOP, fetch_misaligned=0.
- Latency: issue in cycle N -> data pushed at end of N+1 -> fetch_valid in N+2.
- Redirect penalty: flush in cycle F -> target instruction valid at F+3.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. count saturates logically at DEPTH and never exceeds it.
- occupancy = count (registered).
- rst asserted mid-operation has the same effect as flush and also forces stall_out=1.

Decomposition:
- Package fetch_pkg: XLEN, NOP_INSTR=32'h00000013, packed struct fetch_entry_t {pc, instr, misaligned}.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, clear, count, head.
  - Parameter: DEPTH.
- The top holds the issue/credit logic and in-flight register.

Test Plan:
- Streaming: reset 2 cycles, pc_in steps 0,4,8,..., fetch_ready=1, DEPTH=4, imem returns mem[addr] -> first fetch_valid 2 cycles after reset release with fetch_pc=0; thereafter one instr/cycle, stall_out=0 steady.
- Backpressure: fetch_ready=0 from start -> occupancy climbs 0..4; stall_out=1 once count+inflight=4; PC holds at 16; no entry lost or duplicated after fetch_ready=1.
- Flush with full queue: queue full (pcs 0x0-0xC), inflight=1, assert flush one cycle with jump 0x100 -> next cycle occupancy=0, fetch_valid=0; response in flush cycle dropped; fetch_pc=0x100 valid 3 cycles after flush.
- Flush coincident with pop and push: count=2, fetch_ready=1, response arriving, flush=1 -> count=0 next cycle, no push, no pop side-effect.
- Misaligned: pc_in=0x102 issued -> entry with fetch_pc=0x102, fetch_misaligned=1; the following aligned entry has misaligned=0.
- Reset mid-stream: rst=1 for 1 cycle while count=3 -> outputs return to reset values next cycle; stall_out=1 during rst; fetching resumes from PC 0 after release.
